// File: rtl/ela_pkg.sv
// Shared types and constants for the ELA frame scheduler and its frame-SRAM arbiter.
package ela_pkg;

    localparam int unsigned IMG_W      = 128;
    localparam int unsigned IMG_ROWS   = 63;
    localparam int unsigned ROW_ADDR_W = 13;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned WR_CNT_W   = 14;
    localparam int unsigned EXP_WR_DEF = IMG_ROWS * IMG_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CRST = 3'd1,
        ST_KICK = 3'd2,
        ST_RUN  = 3'd3,
        ST_NEXT = 3'd4,
        ST_FIN  = 3'd5
    } sched_state_t;

endpackage

// File: rtl/ela_mem_arb.sv
// Frame-SRAM arbiter: core writes always win, host reads take any free cycle.
module ela_mem_arb
    import ela_pkg::*;
#(
    parameter int unsigned FR_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FR_W-1:0]            frame_idx,
    input  logic                       core_wen,
    input  logic [ROW_ADDR_W-1:0]      core_addr,
    input  logic [DATA_W-1:0]          core_wdata,
    input  logic                       hr_req,
    input  logic [ROW_ADDR_W+FR_W-1:0] hr_addr,
    output logic                       hr_gnt,
    output logic                       hr_rvalid,
    output logic [DATA_W-1:0]          hr_rdata,
    output logic                       mem_cen,
    output logic                       mem_wen,
    output logic [ROW_ADDR_W+FR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);

    // The core cannot stall, so its write owns the port in the same cycle.
    always_comb begin
        hr_gnt    = hr_req & ~core_wen;
        mem_cen   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_wen) begin
            mem_cen   = 1'b1;
            mem_wen   = 1'b1;
            mem_addr  = {frame_idx, core_addr};
            mem_wdata = core_wdata;
        end else if (hr_req) begin
            mem_cen  = 1'b1;
            mem_addr = hr_addr;
        end
    end

    // Read data arrives one cycle after the grant, matching SRAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr_rvalid <= 1'b0;
        end else begin
            hr_rvalid <= hr_gnt;
        end
    end

    assign hr_rdata = hr_rvalid ? mem_rdata : '0;

endmodule

// File: rtl/ela_mem_sched.sv
// ELA frame scheduler: resets and kicks the core once per frame, shares the frame SRAM with host reads.
// Define ELA_SCHED_WRCHK_EN to add the per-frame write-count check and the sticky wr_err output.
module ela_mem_sched
    import ela_pkg::*;
#(
    parameter int unsigned FR_W   = 3,
    parameter int unsigned EXP_WR = EXP_WR_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [FR_W-1:0]            nframes,
    output logic                       busy,
    output logic                       job_done,
    output logic                       core_rst,
    output logic                       core_ready,
    input  logic                       core_done,
    input  logic                       core_wen,
    input  logic [ROW_ADDR_W-1:0]      core_addr,
    input  logic [DATA_W-1:0]          core_wdata,
    input  logic                       hr_req,
    input  logic [ROW_ADDR_W+FR_W-1:0] hr_addr,
    output logic                       hr_gnt,
    output logic                       hr_rvalid,
    output logic [DATA_W-1:0]          hr_rdata,
    output logic                       mem_cen,
    output logic                       mem_wen,
    output logic [ROW_ADDR_W+FR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
`ifdef ELA_SCHED_WRCHK_EN
    output logic                       wr_err,
`endif
    output logic [FR_W-1:0]            frame_idx
);

    if (EXP_WR >= 2**WR_CNT_W) begin : g_exp_wr_range
        $error("EXP_WR does not fit the per-frame write counter");
    end

    sched_state_t    state_q, state_d;
    logic [FR_W-1:0] nframes_q, nframes_d, frame_idx_d;
    logic            busy_d, job_done_d, core_rst_d, core_ready_d;

    // State and registered outputs; the core is held in reset while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            nframes_q  <= '0;
            frame_idx  <= '0;
            busy       <= 1'b0;
            job_done   <= 1'b0;
            core_rst   <= 1'b1;
            core_ready <= 1'b0;
        end else begin
            state_q    <= state_d;
            nframes_q  <= nframes_d;
            frame_idx  <= frame_idx_d;
            busy       <= busy_d;
            job_done   <= job_done_d;
            core_rst   <= core_rst_d;
            core_ready <= core_ready_d;
        end
    end

    // Next state and frame bookkeeping.
    always_comb begin
        state_d     = state_q;
        nframes_d   = nframes_q;
        frame_idx_d = frame_idx;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_CRST;
                    nframes_d   = nframes;
                    frame_idx_d = '0;
                end
            end
            ST_CRST: state_d = ST_KICK;
            ST_KICK: state_d = ST_RUN;
            ST_RUN: begin
                if (core_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (frame_idx == nframes_q) begin
                    state_d = ST_FIN;
                end else begin
                    state_d     = ST_CRST;
                    frame_idx_d = frame_idx + FR_W'(1);
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they line up with the state register.
    always_comb begin
        busy_d       = 1'b0;
        job_done_d   = 1'b0;
        core_rst_d   = 1'b0;
        core_ready_d = 1'b0;
        case (state_d)
            ST_CRST: begin busy_d = 1'b1; core_rst_d = 1'b1; end
            ST_KICK: begin busy_d = 1'b1; core_ready_d = 1'b1; end
            ST_RUN:  busy_d = 1'b1;
            ST_NEXT: busy_d = 1'b1;
            ST_FIN:  job_done_d = 1'b1;
            default: ;
        endcase
    end

    ela_mem_arb #(
        .FR_W (FR_W)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .frame_idx  (frame_idx),
        .core_wen   (core_wen),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .hr_req     (hr_req),
        .hr_addr    (hr_addr),
        .hr_gnt     (hr_gnt),
        .hr_rvalid  (hr_rvalid),
        .hr_rdata   (hr_rdata),
        .mem_cen    (mem_cen),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

`ifdef ELA_SCHED_WRCHK_EN
    logic [WR_CNT_W-1:0] wr_cnt;

    // Counts core writes per frame; a short or long frame latches wr_err until the next job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
            wr_err <= 1'b0;
        end else begin
            if (state_q == ST_CRST) begin
                wr_cnt <= '0;
            end else if (core_wen) begin
                wr_cnt <= wr_cnt + WR_CNT_W'(1);
            end
            if (state_q == ST_IDLE && start) begin
                wr_err <= 1'b0;
            end else if (state_q == ST_NEXT && wr_cnt != WR_CNT_W'(EXP_WR)) begin
                wr_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ela_mem_sched.sv
// Randomized bench for ela_mem_sched: behavioural core, host and SRAM models plus a reference memory.
module tb_ela_mem_sched;
    import ela_pkg::*;

    localparam int unsigned FR_W  = 3;
    localparam int unsigned AW    = ROW_ADDR_W + FR_W;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [FR_W-1:0] nframes;
    logic busy, job_done, core_rst, core_ready, core_done, core_wen;
    logic [ROW_ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic hr_req, hr_gnt, hr_rvalid;
    logic [AW-1:0] hr_addr;
    logic [DATA_W-1:0] hr_rdata;
    logic mem_cen, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [FR_W-1:0] frame_idx;
`ifdef ELA_SCHED_WRCHK_EN
    logic wr_err;
`endif

    always #5 clk = ~clk;

    ela_mem_sched #(.FR_W(FR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .nframes(nframes),
        .busy(busy), .job_done(job_done), .core_rst(core_rst), .core_ready(core_ready),
        .core_done(core_done), .core_wen(core_wen), .core_addr(core_addr), .core_wdata(core_wdata),
        .hr_req(hr_req), .hr_addr(hr_addr), .hr_gnt(hr_gnt), .hr_rvalid(hr_rvalid), .hr_rdata(hr_rdata),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
`ifdef ELA_SCHED_WRCHK_EN
        .wr_err(wr_err),
`endif
        .frame_idx(frame_idx)
    );

    function automatic logic [7:0] init_val(input logic [AW-1:0] a);
        return (a == '1) ? 8'hA5 : (8'(a) ^ 8'(a >> 8) ^ 8'h3C);
    endfunction

    // Single-port SRAM, read latency 1; unwritten words read back their init pattern.
    logic [DATA_W-1:0] sram [DEPTH];
    logic              sram_v [DEPTH];
    logic              mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) sram_v[i] <= 1'b0;
        end else if (mem_cen) begin
            if (mem_wen) begin
                sram[mem_addr]   <= mem_wdata;
                sram_v[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= sram_v[mem_addr] ? sram[mem_addr] : init_val(mem_addr);
            end
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] ref_mem [DEPTH];
    int cyc = 0, n_rst, n_ready, n_done, exp_frame = 0, t_done = 0, t_jd = 0;
    int wr_left, wr_idx, lat_left, plan_wr, plan_lat, req_wait;
    bit core_run = 0, burst = 0, probe = 0, rand_host = 1, start_req = 0;
    bit rd_pend = 0, last_gnt = 0;
    logic [AW-1:0] rd_addr;
    logic [7:0] rd_exp;
    logic [AW-1:0] hq[$];

    // One clock: observe registered outputs, step the core/host models, then check the port mux.
    task automatic step();
        logic [AW-1:0] a;
        @(negedge clk);
        cyc++;
        if (rd_pend) begin
            check("hr_rvalid", 32'(hr_rvalid), 32'd1);
            check("hr_rdata", 32'(hr_rdata), 32'(rd_exp));
            if (rd_addr == '1) check("probe_rdata", 32'(hr_rdata), 32'hA5);
        end else begin
            check("hr_rvalid_low", 32'(hr_rvalid), 32'd0);
            check("hr_rdata_zero", 32'(hr_rdata), 32'd0);
        end
        rd_pend = 0;
        if (core_rst) begin n_rst++; check("busy_in_crst", 32'(busy), 32'd1); end
        if (core_ready) begin
            n_ready++;
            exp_frame = n_ready - 1;
            check("frame_idx", 32'(frame_idx), 32'(exp_frame));
            check("busy_in_kick", 32'(busy), 32'd1);
        end
        if (job_done) begin n_done++; t_jd = cyc; check("busy_at_done", 32'(busy), 32'd0); end

        if (core_rst) begin
            core_done = 0; core_run = 0; core_wen = 0;
        end else if (core_ready) begin
            core_run = 1; wr_left = plan_wr; wr_idx = 0; lat_left = plan_lat; core_wen = 0;
        end else if (core_run) begin
            if (wr_left > 0 && (burst || $urandom_range(1, 0) == 1)) begin
                core_wen   = 1;
                core_addr  = (wr_idx == 0) ? 13'd5 : 13'($urandom_range(8063, 0));
                core_wdata = 8'($urandom);
                if (probe && wr_idx == 0) hq.push_back('1);
                wr_idx++; wr_left--;
            end else begin
                core_wen = 0;
                if (wr_left == 0) begin
                    if (lat_left == 0) begin core_done = 1; core_run = 0; t_done = cyc; end
                    else lat_left--;
                end
            end
        end else begin
            core_wen = 0;
        end

        start = start_req; start_req = 0;

        if (hr_req && last_gnt) hr_req = 0;
        if (!hr_req) begin
            if (hq.size() > 0) begin
                hr_req = 1; hr_addr = hq.pop_front(); req_wait = 0;
            end else if (rand_host && $urandom_range(9, 0) < 3) begin
                hr_req = 1; hr_addr = AW'($urandom); req_wait = 0;
            end
        end

        #1;
        check("hr_gnt", 32'(hr_gnt), core_wen ? 32'd0 : 32'(hr_req));
        last_gnt = 0;
        if (core_wen) begin
            a = {FR_W'(exp_frame), core_addr};
            check("wr_cen", 32'(mem_cen), 32'd1);
            check("wr_wen", 32'(mem_wen), 32'd1);
            check("wr_addr", 32'(mem_addr), 32'(a));
            check("wr_data", 32'(mem_wdata), 32'(core_wdata));
            if (exp_frame == 2 && core_addr == 13'd5) check("f2_addr", 32'(mem_addr), 32'h4005);
            ref_mem[a] = core_wdata;
            if (hr_req) req_wait++;
        end else if (hr_req) begin
            check("rd_cen", 32'(mem_cen), 32'd1);
            check("rd_wen", 32'(mem_wen), 32'd0);
            check("rd_addr", 32'(mem_addr), 32'(hr_addr));
            if (probe && hr_addr == '1) check("burst_wait", 32'(req_wait), 32'd5);
            last_gnt = 1; rd_pend = 1; rd_addr = hr_addr; rd_exp = ref_mem[hr_addr];
        end else begin
            check("idle_cen", 32'(mem_cen), 32'd0);
            check("idle_addr", 32'(mem_addr), 32'd0);
            check("idle_wdata", 32'(mem_wdata), 32'd0);
        end
    endtask

    task automatic run_job(input int nf, input int nwr, input int lat, input bit bst,
                           input bit prb, input bit mid_start);
        bit got = 0, ms_done = 0;
        int budget;
        nframes = FR_W'(nf); plan_wr = nwr; plan_lat = lat; burst = bst; probe = prb;
        n_rst = 0; n_ready = 0; n_done = 0;
        start_req = 1;
        budget = (nf + 1) * (6 * nwr + lat + 30) + 50;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (job_done) got = 1;
            if (mid_start && !ms_done && n_ready == 1 && core_run && !core_ready) begin
                start_req = 1; ms_done = 1;
            end
        end
        check("job_done_seen", 32'(got), 32'd1);
        check("n_core_rst", 32'(n_rst), 32'(nf + 1));
        check("n_core_ready", 32'(n_ready), 32'(nf + 1));
        check("n_job_done", 32'(n_done), 32'd1);
        check("done_latency", 32'(t_jd - t_done), 32'd2);
        step();
        check("job_done_pulse", 32'(job_done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic abort_test();
        bit hit = 0;
        nframes = FR_W'(3); plan_wr = 4; plan_lat = 30; burst = 0; probe = 0;
        n_rst = 0; n_ready = 0; n_done = 0;
        start_req = 1;
        for (int i = 0; i < 500 && !hit; i++) begin
            step();
            hit = (n_ready == 2) && core_run && !core_ready && !core_wen;
        end
        check("abort_in_f1_run", 32'(hit), 32'd1);
        rst = 1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_frame_idx", 32'(frame_idx), 32'd0);
        check("rst_job_done", 32'(job_done), 32'd0);
        check("rst_core_ready", 32'(core_ready), 32'd0);
        core_run = 0; core_wen = 0; core_done = 0; hr_req = 0;
        hq.delete(); rd_pend = 0; last_gnt = 0;
        repeat (3) @(negedge clk);
        check("rst_hold_core_rst", 32'(core_rst), 32'd1);
        check("rst_hold_rvalid", 32'(hr_rvalid), 32'd0);
        rst = 0;
        n_done = 0;
        step();
        check("core_rst_release", 32'(core_rst), 32'd0);
        repeat (4) step();
        check("no_job_done_abort", 32'(n_done), 32'd0);
        check("idle_after_abort", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1; start = 0; nframes = '0; core_done = 0; core_wen = 0; core_addr = '0;
        core_wdata = '0; hr_req = 0; hr_addr = '0; mem_clr = 1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(AW'(i));
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_job_done", 32'(job_done), 32'd0);
        check("reset_core_rst", 32'(core_rst), 32'd1);
        check("reset_core_ready", 32'(core_ready), 32'd0);
        check("reset_frame_idx", 32'(frame_idx), 32'd0);
        check("reset_hr_rvalid", 32'(hr_rvalid), 32'd0);
        check("reset_mem_cen", 32'(mem_cen), 32'd0);
        mem_clr = 0; rst = 0;
        step();
        check("core_rst_after_reset", 32'(core_rst), 32'd0);

        run_job(0, 0, 10, 1'b0, 1'b0, 1'b0);
        run_job(2, 3, 2, 1'b0, 1'b0, 1'b0);
        rand_host = 0;
        repeat (3) step();
        run_job(0, 5, 3, 1'b1, 1'b1, 1'b0);
        rand_host = 1;
        run_job(2, 4, 5, 1'b0, 1'b0, 1'b1);
        abort_test();
        run_job(1, 3, 4, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 12; j++) begin
            run_job(int'($urandom_range(3, 0)), int'($urandom_range(12, 0)),
                    int'($urandom_range(6, 0)), 1'($urandom_range(1, 0)), 1'b0, 1'b0);
            repeat (int'($urandom_range(4, 0))) step();
        end
`ifdef ELA_SCHED_WRCHK_EN
        rand_host = 0;
        run_job(0, 8063, 2, 1'b1, 1'b0, 1'b0);
        check("wr_err_short", 32'(wr_err), 32'd1);
        run_job(0, 8064, 2, 1'b1, 1'b0, 1'b0);
        check("wr_err_exact", 32'(wr_err), 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ela_mem_sched.md
ELA_MEM_SCHED -- requirements
Module: ela_mem_sched

Interface
REQ-001 Parameter FR_W, default 3: frame-index width; up to 2^FR_W frames, memory address width 13+FR_W.
REQ-002 Parameter EXP_WR, default 8064: number of core writes expected per frame (63 rows x 128).
REQ-003 Clock clk, rising edge; reset rst, asynchronous, active-high.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  async active-high reset.
REQ-006 start  in  1  one-cycle pulse; launches a job, ignored while busy.
REQ-007 nframes  in  FR_W  frames per job minus one; sampled on start.
REQ-008 busy  out  1  job in progress.
REQ-009 job_done  out  1  one-cycle pulse after the last frame.
REQ-010 core_rst  out  1  synchronous reset pulse to the ELA core.
REQ-011 core_ready  out  1  one-cycle frame-start strobe to the core.
REQ-012 core_done  in  1  sticky core completion flag.
REQ-013 core_wen / core_addr / core_wdata  in  1/13/8  core write port.
REQ-014 hr_req / hr_addr  in  1/13+FR_W  host read request, held until granted.
REQ-015 hr_gnt  out  1  host request accepted this cycle.
REQ-016 hr_rvalid / hr_rdata  out  1/8  read return, one cycle after hr_gnt.
REQ-017 mem_cen / mem_wen / mem_addr / mem_wdata  out  1/1/13+FR_W/8  single-port SRAM; mem_rdata in 8, latency 1.
REQ-018 frame_idx  out  FR_W  frame currently processed.

Function
REQ-019 FSM states IDLE, CRST, KICK, RUN, NEXT, FIN; one state register, registered outputs.
REQ-020 IDLE->CRST on start; latch nframes, frame_idx=0, busy=1.
REQ-021 CRST: core_rst=1 exactly one cycle, then KICK.
REQ-022 KICK: core_ready=1 exactly one cycle, then RUN.
REQ-023 RUN: remain until core_done=1, then NEXT.
REQ-024 NEXT: if frame_idx==latched nframes -> FIN, else frame_idx+1 -> CRST.
REQ-025 FIN: job_done=1 one cycle, busy=0, -> IDLE; core_rst held 0 (core stays in done).
REQ-026 Write path combinational: core_wen=1 -> mem_cen=1, mem_wen=1, mem_addr={frame_idx,core_addr}, mem_wdata=core_wdata, same cycle.
REQ-027 Core writes have absolute priority (core cannot stall); hr_gnt=0 in any cycle with core_wen=1.
REQ-028 hr_gnt=hr_req & ~core_wen; on grant mem_cen=1, mem_wen=0, mem_addr=hr_addr.
REQ-029 hr_rvalid registered copy of hr_gnt; hr_rdata=mem_rdata when hr_rvalid=1, else 0.
REQ-030 Host reads are legal in every state, including IDLE and mid-frame.
REQ-031 start while busy ignored; core_done outside RUN ignored.
REQ-032 No SRAM access cycle: mem_cen=0, mem_addr/mem_wdata hold 0.

Reset
REQ-033 rst asserted: state=IDLE, busy=0, job_done=0, core_rst=1 (core held in reset), core_ready=0, frame_idx=0, hr_rvalid=0, counters 0.
REQ-034 rst mid-job aborts immediately; no job_done; first cycle after release core_rst=0.

Configuration
REQ-035 Macro ELA_SCHED_WRCHK_EN defined: per-frame write counter (14 bits) cleared in CRST, incremented per core_wen; in NEXT, count!=EXP_WR sets sticky output wr_err (cleared on start).
REQ-036 Macro undefined: no counter, wr_err port absent, timing unchanged.

Structure
REQ-037 Shared package ela_pkg: state enum, IMG_W=128, ROW_ADDR_W=13, EXP_WR default.
REQ-038 One sub-module natural: ela_mem_arb (REQ-026..029), FSM in top.

Verification
REQ-039 nframes=0, start, model core done after 10 cycles -> one core_rst, one core_ready, job_done 1 cycle after NEXT, busy falls.
REQ-040 nframes=2 -> exactly 3 core_rst/core_ready pairs, frame_idx 0,1,2, core_addr 0x0005 in frame 2 writes mem_addr 0x4005.
REQ-041 hr_req held during core_wen burst of 5 -> hr_gnt 0 for 5 cycles, granted cycle 6, hr_rvalid next cycle with preloaded data 0xA5.
REQ-042 rst asserted in RUN of frame 1 -> IDLE, core_rst=1, no job_done; fresh start restarts at frame 0.
REQ-043 With ELA_SCHED_WRCHK_EN, core issuing 8063 writes -> wr_err=1 at NEXT; 8064 writes -> wr_err=0.
REQ-044 start pulsed during RUN -> ignored, frame sequence unchanged.
